fifo_rd_arb: RTL and testbench

Read-side arbiter for the asynchronous FIFO. It shares the single FIFO read port (`rinc`/`rdata`/`rempty`) among `NREQ` consumers in the read clock domain. Grants are round-robin, and each grant is a bounded burst of up to `BURST` words. Each popped word is returned registered and tagged with the requester id. The block sits between the FIFO read interface and the consumer logic.

---
 rtl/fifo_rd_arb_pkg.sv | 14 +
 rtl/fifo_rd_arb_if.sv | 36 +++
 rtl/fifo_rd_arb_pick.sv | 35 +++
 rtl/fifo_rd_arb.sv | 119 +++++++++++
 tb/tb_fifo_rd_arb.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_arb_pkg.sv
// rtl/fifo_rd_arb_pkg.sv - shared constants and FSM state type for the FIFO read arbiter
// Package definitions:
//   DATASIZE, ADDRSIZE : async FIFO word width and address width
//   NREQ               : default number of read-side consumers
//   BURST_LEN          : default maximum words per grant (the enum below owns the name BURST)
//   arb_state_t        : arbiter FSM state, IDLE or BURST
package definitions;
  localparam int DATASIZE  = 8;
  localparam int ADDRSIZE  = 4;
  localparam int NREQ      = 4;
  localparam int BURST_LEN = 8;

  typedef enum logic {IDLE, BURST} arb_state_t;
endpackage

// File: rtl/fifo_rd_arb_if.sv
// rtl/fifo_rd_arb_if.sv - FIFO read port plus consumer-side grant/data bundle
// Signals:
//   req[NREQ]         : level request per consumer
//   rempty, rdata     : FIFO empty flag (rclk domain) and head-of-FIFO word
//   rinc              : FIFO pop strobe
//   gnt[NREQ]         : one-hot current grant, zero when idle
//   dout, dout_valid  : registered popped word and its one-cycle valid
//   dout_id           : requester index that owns dout
//   busy              : a burst is in progress
// Modports: master = FIFO/consumer side, slave = arbiter.
interface fifo_rd_arb_if #(
  parameter int NREQ     = definitions::NREQ,
  parameter int DATASIZE = definitions::DATASIZE
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]     req;
  logic                rempty;
  logic [DATASIZE-1:0] rdata;
  logic                rinc;
  logic [NREQ-1:0]     gnt;
  logic [DATASIZE-1:0] dout;
  logic                dout_valid;
  logic [IDW-1:0]      dout_id;
  logic                busy;

  modport master (
    output req, rempty, rdata,
    input  rinc, gnt, dout, dout_valid, dout_id, busy
  );

  modport slave (
    input  req, rempty, rdata,
    output rinc, gnt, dout, dout_valid, dout_id, busy
  );
endinterface

// File: rtl/fifo_rd_arb_pick.sv
// rtl/fifo_rd_arb_pick.sv - combinational round-robin picker (module rr_arb_pick)
// Ports:
//   req[NREQ]     : in  - request vector
//   last[IDW]     : in  - index granted most recently
//   pick[NREQ]    : out - one-hot first asserted request searching upward from last+1
//   pick_idx[IDW] : out - index of pick (0 when no request)
module rr_arb_pick #(
  parameter int NREQ = definitions::NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] pick,
  output logic [IDW-1:0]  pick_idx
);
  logic           found;
  logic [IDW-1:0] j;

  // Walk last+1 .. last+NREQ modulo NREQ; the final step wraps back to last
  // itself so a lone requester is re-granted.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    j        = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = IDW'((int'(last) + i) % NREQ);
      if (!found && req[j]) begin
        found    = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = j;
      end
    end
  end
endmodule

// File: rtl/fifo_rd_arb.sv
// rtl/fifo_rd_arb.sv - round-robin burst arbiter sharing one async-FIFO read port
// Ports:
//   rclk          : in  - read-domain clock
//   rrst          : in  - asynchronous active-high reset
//   bus           : fifo_rd_arb_if.slave - req/rempty/rdata in, rinc/gnt/dout/dout_valid/dout_id/busy out
//   stats_clr     : in  - (FIFO_RD_ARB_STATS_EN only) synchronous clear of word_cnt
//   word_cnt[NREQ]: out - (FIFO_RD_ARB_STATS_EN only) saturating 16-bit popped-word count per requester
// Optional feature macro: FIFO_RD_ARB_STATS_EN.
module fifo_rd_arb #(
  parameter int NREQ     = definitions::NREQ,
  parameter int BURST    = definitions::BURST_LEN,
  parameter int DATASIZE = definitions::DATASIZE
) (
  input  logic        rclk,
  input  logic        rrst,
`ifdef FIFO_RD_ARB_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] word_cnt [NREQ],
`endif
  fifo_rd_arb_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(BURST + 1);

  definitions::arb_state_t state, state_nxt;

  logic [IDW-1:0]  last;      // round-robin pointer, also the index of the active grant
  logic [CW-1:0]   cnt;       // words popped in the current grant
  logic [NREQ-1:0] gnt_q;
  logic            busy_q;
  logic [NREQ-1:0] pick;
  logic [IDW-1:0]  pick_idx;
  logic            pop;
  logic            burst_end;

  rr_arb_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req      (bus.req),
    .last     (last),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) state <= definitions::IDLE;
    else      state <= state_nxt;
  end

  // An empty FIFO only stalls the burst; dropping the granted request ends it
  // without a pop in that cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    burst_end = 1'b0;
    case (state)
      definitions::IDLE: begin
        if (|bus.req) state_nxt = definitions::BURST;
      end
      definitions::BURST: begin
        pop       = bus.req[last] && !bus.rempty && (cnt < CW'(BURST));
        burst_end = !bus.req[last] || (pop && (cnt == CW'(BURST - 1)));
        if (burst_end) state_nxt = definitions::IDLE;
      end
      default: state_nxt = definitions::IDLE;
    endcase
  end

  assign bus.rinc = pop;
  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      gnt_q  <= '0;
      busy_q <= 1'b0;
      last   <= IDW'(NREQ - 1);
      cnt    <= '0;
    end else if (state == definitions::IDLE) begin
      if (|bus.req) begin
        gnt_q  <= pick;
        last   <= pick_idx;
        cnt    <= '0;
        busy_q <= 1'b1;
      end
    end else begin
      if (pop) cnt <= cnt + 1'b1;
      if (burst_end) begin
        gnt_q  <= '0;
        busy_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_id    <= '0;
    end else begin
      bus.dout_valid <= pop;
      if (pop) begin
        bus.dout    <= bus.rdata;
        bus.dout_id <= last;
      end
    end
  end

`ifdef FIFO_RD_ARB_STATS_EN
  // Clear wins over a same-cycle pop; counts stick at all-ones.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      for (int i = 0; i < NREQ; i++) word_cnt[i] <= '0;
    end else if (stats_clr) begin
      for (int i = 0; i < NREQ; i++) word_cnt[i] <= '0;
    end else if (pop && (word_cnt[last] != 16'hFFFF)) begin
      word_cnt[last] <= word_cnt[last] + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_rd_arb.sv
// tb/tb_fifo_rd_arb.sv - self-checking bench for fifo_rd_arb against a queue-based FIFO and round-robin model
module tb_fifo_rd_arb;
  localparam int NREQ  = 4;
  localparam int BURST = 8;
  localparam int DW    = definitions::DATASIZE;
  localparam int IDW   = $clog2(NREQ);

  logic rclk = 1'b0;
  logic rrst;
  always #5 rclk = ~rclk;

  fifo_rd_arb_if #(.NREQ(NREQ), .DATASIZE(DW)) bus ();

`ifdef FIFO_RD_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] word_cnt [NREQ];
`endif

  fifo_rd_arb #(.NREQ(NREQ), .BURST(BURST), .DATASIZE(DW)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
`ifdef FIFO_RD_ARB_STATS_EN
    .stats_clr (stats_clr),
    .word_cnt  (word_cnt),
`endif
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq[$];
  int cyc;
  logic s_rinc, s_rempty, s_busy, s_dv;
  logic [NREQ-1:0] s_gnt, s_gnt_prev;
  logic [DW-1:0] s_dout;
  logic [IDW-1:0] s_id;
  int dv_id_log[$];
  logic [DW-1:0] dv_data_log[$];
  int grant_log[$];
  int pop_cyc_log[$];
  int bad_rinc, bad_onehot;

  function automatic int rr_next(input logic [NREQ-1:0] mask, input int from);
    for (int i = 1; i <= NREQ; i++)
      if (mask[(from + i) % NREQ]) return (from + i) % NREQ;
    return -1;
  endfunction

  task automatic fifo_sync();
    bus.rempty = (fq.size() == 0);
    bus.rdata  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic clear_logs();
    dv_id_log.delete(); dv_data_log.delete(); grant_log.delete(); pop_cyc_log.delete();
    bad_rinc = 0; bad_onehot = 0; s_gnt_prev = '0; cyc = 0;
  endtask

  // One clock: sample at negedge, then apply the FIFO pop just after posedge.
  task automatic tick();
    int gi;
    @(negedge rclk);
    s_rinc = bus.rinc; s_rempty = bus.rempty; s_busy = bus.busy; s_gnt = bus.gnt;
    s_dv = bus.dout_valid; s_dout = bus.dout; s_id = bus.dout_id;
    if (s_rinc) pop_cyc_log.push_back(cyc);
    if (s_dv) begin dv_id_log.push_back(int'(s_id)); dv_data_log.push_back(s_dout); end
    if (s_gnt != '0 && s_gnt_prev == '0) begin
      gi = -1;
      for (int i = 0; i < NREQ; i++) if (s_gnt[i]) gi = i;
      grant_log.push_back(gi);
    end
    if (s_rinc && s_rempty) bad_rinc++;
    if ($countones(s_gnt) > 1) bad_onehot++;
    s_gnt_prev = s_gnt;
    cyc++;
    @(posedge rclk); #1;
    if (s_rinc && fq.size() != 0) void'(fq.pop_front());
    fifo_sync();
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    bus.req = '0;
    fq.delete();
    fifo_sync();
    @(posedge rclk); @(posedge rclk); #1;
    rrst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rrst = 1'b1;
    #1;
    checks++; if (bus.gnt !== '0) begin errors++; $display("FAIL reset_gnt got %b want 0", bus.gnt); end
    checks++; if (bus.rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc got %b want 0", bus.rinc); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", bus.dout_valid); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", bus.dout); end
    checks++; if (bus.dout_id !== '0) begin errors++; $display("FAIL reset_id got %h want 0", bus.dout_id); end
    bus.req = '1;
    fq.push_back(DW'($urandom)); fifo_sync();
    @(posedge rclk); @(posedge rclk); #1;
    checks++; if (bus.gnt !== '0 || bus.rinc !== 1'b0) begin errors++; $display("FAIL reset_hold got gnt=%b rinc=%b want 0", bus.gnt, bus.rinc); end
    rrst = 1'b0; bus.req = '0; fq.delete(); fifo_sync();
    clear_logs();
    tick();
    checks++; if (s_gnt !== '0 || s_busy !== 1'b0) begin errors++; $display("FAIL reset_idle got gnt=%b busy=%b want 0", s_gnt, s_busy); end
  endtask

  task automatic test_short_burst();
    logic [DW-1:0] w[3];
    do_reset(); clear_logs();
    for (int i = 0; i < 3; i++) begin w[i] = DW'($urandom); fq.push_back(w[i]); end
    fifo_sync();
    bus.req = NREQ'(1);
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++; if (s_rinc !== (c >= 1 && c <= 3)) begin errors++; $display("FAIL short_rinc c%0d got %b want %b", c, s_rinc, (c >= 1 && c <= 3)); end
      checks++; if (s_gnt !== ((c >= 1) ? NREQ'(1) : NREQ'(0))) begin errors++; $display("FAIL short_gnt c%0d got %b", c, s_gnt); end
      checks++; if (s_dv !== (c >= 2 && c <= 4)) begin errors++; $display("FAIL short_dv c%0d got %b want %b", c, s_dv, (c >= 2 && c <= 4)); end
      if (c >= 2 && c <= 4) begin
        checks++; if (s_dout !== w[c-2] || s_id !== '0) begin errors++; $display("FAIL short_dout c%0d got %h/%0d want %h/0", c, s_dout, s_id, w[c-2]); end
      end
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL short_stall_busy got %b want 1", bus.busy); end
    bus.req = '0;
    tick(); tick();
    checks++; if (s_gnt !== '0 || s_busy !== 1'b0) begin errors++; $display("FAIL short_release got gnt=%b busy=%b want 0", s_gnt, s_busy); end
  endtask

  task automatic test_req_drop();
    logic [DW-1:0] w[$];
    do_reset(); clear_logs();
    for (int i = 0; i < 10; i++) begin w.push_back(DW'($urandom)); fq.push_back(w[i]); end
    fifo_sync();
    bus.req = NREQ'(2);
    repeat (4) tick();
    bus.req = '0;
    tick();
    checks++; if (s_rinc !== 1'b0) begin errors++; $display("FAIL drop_rinc got %b want 0", s_rinc); end
    checks++; if (s_gnt !== NREQ'(2)) begin errors++; $display("FAIL drop_gnt_held got %b want 0010", s_gnt); end
    tick();
    checks++; if (s_gnt !== '0 || s_busy !== 1'b0) begin errors++; $display("FAIL drop_idle got gnt=%b busy=%b want 0", s_gnt, s_busy); end
    tick();
    checks++; if (dv_id_log.size() != 3) begin errors++; $display("FAIL drop_count got %0d want 3", dv_id_log.size()); end
    for (int k = 0; k < 3 && k < dv_id_log.size(); k++) begin
      checks++; if (dv_id_log[k] != 1 || dv_data_log[k] !== w[k]) begin errors++; $display("FAIL drop_word%0d got %0d/%h want 1/%h", k, dv_id_log[k], dv_data_log[k], w[k]); end
    end
    checks++; if (fq.size() != 7) begin errors++; $display("FAIL drop_left got %0d want 7", fq.size()); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w[$];
    int gs[$];
    int g, n;
    do_reset(); clear_logs();
    n = 5 * BURST;
    for (int i = 0; i < n; i++) begin w.push_back(DW'($urandom)); fq.push_back(w[i]); end
    fifo_sync();
    bus.req = '1;
    g = NREQ - 1;
    for (int k = 0; k < 5; k++) begin g = rr_next('1, g); gs.push_back(g); end
    for (int c = 0; c < 200 && pop_cyc_log.size() < n; c++) tick();
    bus.req = '0;
    repeat (3) tick();
    checks++; if (pop_cyc_log.size() != n) begin errors++; $display("FAIL b2b_pops got %0d want %0d", pop_cyc_log.size(), n); end
    if (pop_cyc_log.size() == n) begin
      checks++; if (pop_cyc_log[n-1] - pop_cyc_log[0] + 1 != n + 4) begin errors++; $display("FAIL b2b_span got %0d want %0d", pop_cyc_log[n-1] - pop_cyc_log[0] + 1, n + 4); end
    end
    checks++; if (grant_log.size() != 5) begin errors++; $display("FAIL b2b_grants got %0d want 5", grant_log.size()); end
    for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
      checks++; if (grant_log[k] != gs[k]) begin errors++; $display("FAIL b2b_order%0d got %0d want %0d", k, grant_log[k], gs[k]); end
    end
    for (int k = 0; k < n && k < dv_id_log.size(); k++) begin
      checks++; if (dv_id_log[k] != gs[k / BURST] || dv_data_log[k] !== w[k]) begin errors++; $display("FAIL b2b_word%0d got %0d/%h want %0d/%h", k, dv_id_log[k], dv_data_log[k], gs[k / BURST], w[k]); end
    end
  endtask

  task automatic test_random_stall();
    localparam int NG = 4;
    logic [NREQ-1:0] mask;
    logic [DW-1:0] w[$];
    int gs[$];
    int g;
    for (int it = 0; it < 4; it++) begin
      mask = (it == 0) ? NREQ'(4'b0101) : NREQ'($urandom_range(1, (1 << NREQ) - 1));
      do_reset(); clear_logs();
      w.delete(); gs.delete();
      g = NREQ - 1;
      for (int k = 0; k < NG; k++) begin g = rr_next(mask, g); gs.push_back(g); end
      bus.req = mask;
      for (int c = 0; c < 600 && dv_id_log.size() < NG * BURST; c++) begin
        if (w.size() < NG * BURST && $urandom_range(0, 3) != 0) begin
          w.push_back(DW'($urandom)); fq.push_back(w[w.size()-1]); fifo_sync();
        end
        tick();
      end
      bus.req = '0;
      repeat (3) tick();
      checks++; if (dv_id_log.size() != NG * BURST) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", it, dv_id_log.size(), NG * BURST); end
      for (int k = 0; k < NG * BURST && k < dv_id_log.size(); k++) begin
        checks++; if (dv_id_log[k] != gs[k / BURST] || dv_data_log[k] !== w[k]) begin errors++; $display("FAIL rnd%0d_word%0d got %0d/%h want %0d/%h", it, k, dv_id_log[k], dv_data_log[k], gs[k / BURST], w[k]); end
      end
      checks++; if (bad_rinc != 0) begin errors++; $display("FAIL rnd%0d_rinc_empty got %0d want 0", it, bad_rinc); end
      checks++; if (bad_onehot != 0) begin errors++; $display("FAIL rnd%0d_onehot got %0d want 0", it, bad_onehot); end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset(); clear_logs();
    for (int i = 0; i < 20; i++) fq.push_back(DW'($urandom | 1));
    fifo_sync();
    bus.req = NREQ'(4);
    for (int c = 0; c < 20 && pop_cyc_log.size() < 4; c++) tick();
    checks++; if (pop_cyc_log.size() != 4) begin errors++; $display("FAIL mid_pops got %0d want 4", pop_cyc_log.size()); end
    rrst = 1'b1;
    #1;
    checks++; if (bus.gnt !== '0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_gnt got gnt=%b busy=%b want 0", bus.gnt, bus.busy); end
    checks++; if (bus.rinc !== 1'b0 || bus.dout_valid !== 1'b0) begin errors++; $display("FAIL mid_rinc got rinc=%b dv=%b want 0", bus.rinc, bus.dout_valid); end
    checks++; if (bus.dout !== '0 || bus.dout_id !== '0) begin errors++; $display("FAIL mid_dout got %h/%0d want 0/0", bus.dout, bus.dout_id); end
    @(posedge rclk); #1;
    rrst = 1'b0;
    bus.req = NREQ'(4'b0110);
    clear_logs();
    repeat (3) tick();
    checks++; if (grant_log.size() == 0 || grant_log[0] != 1) begin errors++; $display("FAIL mid_regrant got %0d want 1", grant_log.size() ? grant_log[0] : -1); end
    checks++; if (dv_id_log.size() == 0 || dv_id_log[0] != 1) begin errors++; $display("FAIL mid_first_id got %0d want 1", dv_id_log.size() ? dv_id_log[0] : -1); end
    bus.req = '0;
    repeat (2) tick();
  endtask

`ifdef FIFO_RD_ARB_STATS_EN
  task automatic test_stats();
    do_reset(); clear_logs();
    for (int i = 0; i < NREQ; i++) begin
      checks++; if (word_cnt[i] !== 16'd0) begin errors++; $display("FAIL stats_rst%0d got %0d want 0", i, word_cnt[i]); end
    end
    for (int i = 0; i < 20; i++) fq.push_back(DW'($urandom));
    fifo_sync();
    bus.req = NREQ'(4);
    for (int c = 0; c < 100 && pop_cyc_log.size() < 20; c++) tick();
    tick(); tick();
    for (int i = 0; i < NREQ; i++) begin
      checks++; if (word_cnt[i] !== ((i == 2) ? 16'd20 : 16'd0)) begin errors++; $display("FAIL stats_cnt%0d got %0d want %0d", i, word_cnt[i], (i == 2) ? 20 : 0); end
    end
    fq.push_back(DW'($urandom)); fifo_sync();
    stats_clr = 1'b1;
    #1;
    checks++; if (bus.rinc !== 1'b1) begin errors++; $display("FAIL stats_pop_same_cycle got %b want 1", bus.rinc); end
    tick();
    stats_clr = 1'b0;
    checks++; if (word_cnt[2] !== 16'd0) begin errors++; $display("FAIL stats_clr got %0d want 0", word_cnt[2]); end
    bus.req = '0;
    repeat (2) tick();
  endtask
`endif

  initial begin
    rrst = 1'b0;
    bus.req = '0;
    bus.rempty = 1'b1;
    bus.rdata = '0;
`ifdef FIFO_RD_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    clear_logs();
    test_reset();
    test_short_burst();
    test_req_drop();
    test_back_to_back();
    test_random_stall();
    test_reset_mid_burst();
`ifdef FIFO_RD_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
